uart_mmio_ctrl: RTL and testbench

//  Memory-mapped UART controller between the cpu data port and the UART core.
//  - Decodes the top three data addresses as UART registers; all other addresses pass through to data_mem.
//  - Buffers CPU transmit bytes in a small FIFO and sequences the UART begin/busy handshake.
//  - Captures received bytes into a holding register with valid/overrun status.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_mmio_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART controller: register
// addresses, STATUS bit positions and the transmit sequencer states.
package uart_pkg;

   // UART register window at the top of the data address space
   localparam logic [7:0] A_TXDATA = 8'hFD;
   localparam logic [7:0] A_RXDATA = 8'hFE;
   localparam logic [7:0] A_STATUS = 8'hFF;

   // STATUS = {2'b0, tx_drop, busy_flag, rx_ovr, rx_valid, tx_empty, tx_full}
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_VALID = 2;
   localparam int ST_OVR   = 3;
   localparam int ST_BUSY  = 4;
   localparam int ST_DROP  = 5;

   // Cycles to wait for busy_flag after a begin pulse before giving up
   localparam int BUSY_TIMEOUT = 4;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_LOAD      = 2'd1,
      TX_WAIT_BUSY = 2'd2,
      TX_WAIT_DONE = 2'd3
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage array; contents need no reset because occupancy gates reads
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: decodes the UART register window, buffers
// transmit bytes, sequences the UART begin/busy handshake and captures
// received bytes with valid/overrun status.
//
// Handshake to the UART core: begin_flag is a one-cycle request carrying
// tx_data (tx_data is already stable while begin_flag is high and is held
// until the next load). The core acknowledges by raising busy_flag and
// signals completion by dropping it; a new request is only issued while
// busy_flag is low, and never in consecutive cycles.
module uart_mmio_ctrl
   import uart_pkg::*;
#(
   parameter int TX_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] addr,
   input  logic [7:0] w_data,
   input  logic       mem_w_en,
   input  logic [7:0] dmem_r_data,
   output logic       dmem_w_en,
   output logic [7:0] cpu_r_data,
   output logic       tx_en,
   output logic       rx_en,
   output logic       begin_flag,
   output logic [7:0] tx_data,
   input  logic       busy_flag,
   input  logic       receive_flag,
   input  logic [7:0] rx_data,
   output tx_state_e  dbg_state
);

   tx_state_e  state;
   tx_state_e  state_n;
   logic       uart_hit;
   logic       wr_tx;
   logic       wr_status;
   logic       tx_full;
   logic       tx_empty;
   logic [7:0] tx_head;
   logic       fifo_pop;
   logic       load_data;
   logic [1:0] to_cnt;
   logic       tx_drop;
   logic       rx_valid;
   logic       rx_ovr;
   logic [7:0] rx_hold;
   logic       rx_flag_q;
   logic       rx_rise;
   logic       en_q;
   logic       clr_drop;
   logic       clr_ovr;
   logic       clr_valid;
   logic [7:0] status;

   assign uart_hit  = (addr == A_TXDATA) | (addr == A_RXDATA) | (addr == A_STATUS);
   assign wr_tx     = mem_w_en & (addr == A_TXDATA);
   assign wr_status = mem_w_en & (addr == A_STATUS);
   assign dmem_w_en = mem_w_en & ~uart_hit;
   assign clr_drop  = wr_status & w_data[ST_DROP];
   assign clr_ovr   = wr_status & w_data[ST_OVR];
   assign clr_valid = wr_status & w_data[ST_VALID];
   assign rx_rise   = receive_flag & ~rx_flag_q;
   assign tx_en     = en_q;
   assign rx_en     = en_q;
   assign dbg_state = state;

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (wr_tx),
      .pop     (fifo_pop),
      .din     (w_data),
      .full    (tx_full),
      .empty   (tx_empty),
      .head    (tx_head)
   );

   // Status byte assembly and same-cycle CPU read mux
   always_comb begin
      status           = 8'h00;
      status[ST_FULL]  = tx_full;
      status[ST_EMPTY] = tx_empty;
      status[ST_VALID] = rx_valid;
      status[ST_OVR]   = rx_ovr;
      status[ST_BUSY]  = busy_flag;
      status[ST_DROP]  = tx_drop;
      cpu_r_data       = dmem_r_data;
      if (uart_hit) begin
         case (addr)
            A_RXDATA: cpu_r_data = rx_hold;
            A_STATUS: cpu_r_data = status;
            default:  cpu_r_data = 8'h00;
         endcase
      end
   end

   // UART enables: low while in reset, high from the first clock after
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) en_q <= 1'b0;
      else          en_q <= 1'b1;
   end

   // Sticky drop flag: a store to a full FIFO with no pop this cycle is lost
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) tx_drop <= 1'b0;
      else          tx_drop <= (tx_drop & ~clr_drop) | (wr_tx & tx_full & ~fifo_pop);
   end

   // Receive capture; a new byte beats a same-cycle clear of rx_valid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_flag_q <= 1'b0;
         rx_hold   <= 8'h00;
         rx_valid  <= 1'b0;
         rx_ovr    <= 1'b0;
      end else begin
         rx_flag_q <= receive_flag;
         if (rx_rise) rx_hold <= rx_data;
         rx_valid <= rx_rise | (rx_valid & ~clr_valid);
         rx_ovr   <= (rx_ovr & ~clr_ovr) | (rx_rise & rx_valid & ~clr_valid);
      end
   end

   // Transmit sequencer state, busy timeout counter and tx_data holding register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= TX_IDLE;
         to_cnt  <= 2'd0;
         tx_data <= 8'h00;
      end else begin
         state <= state_n;
         if (state == TX_WAIT_BUSY) to_cnt <= to_cnt + 2'd1;
         else                       to_cnt <= 2'd0;
         if (load_data) tx_data <= tx_head;
      end
   end

   // Transmit sequencer next state; tx_data is loaded on entry to LOAD so it
   // is valid during the begin pulse, and the FIFO is popped in LOAD
   always_comb begin
      state_n    = state;
      fifo_pop   = 1'b0;
      begin_flag = 1'b0;
      load_data  = 1'b0;
      case (state)
         TX_IDLE: begin
            if (!tx_empty && !busy_flag) begin
               state_n   = TX_LOAD;
               load_data = 1'b1;
            end
         end
         TX_LOAD: begin
            begin_flag = 1'b1;
            fifo_pop   = 1'b1;
            state_n    = TX_WAIT_BUSY;
         end
         TX_WAIT_BUSY: begin
            if (busy_flag)                              state_n = TX_WAIT_DONE;
            else if (to_cnt == 2'(BUSY_TIMEOUT - 1))    state_n = TX_IDLE;
         end
         TX_WAIT_DONE: begin
            if (!busy_flag) state_n = TX_IDLE;
         end
         default: state_n = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed scenarios followed by random traffic,
// with expected values from a register-level model and a scoreboard monitor.
module tb_uart_mmio_ctrl;
   import uart_pkg::*;

   localparam int TX_DEPTH = 4;
   localparam int K_DWEN  = 0;
   localparam int K_RD    = 1;
   localparam int K_EN    = 2;
   localparam int K_BEGIN = 3;
   localparam int K_TXD   = 4;
   localparam int K_STATE = 5;

   typedef struct {
      int         kind;
      logic [7:0] val;
   } chk_t;

   // ---------------- clock / reset / DUT ----------------
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] w_data = 8'h00;
   logic       mem_w_en = 1'b0;
   logic [7:0] dmem_r_data;
   logic       dmem_w_en;
   logic [7:0] cpu_r_data;
   logic       tx_en;
   logic       rx_en;
   logic       begin_flag;
   logic [7:0] tx_data;
   logic       busy_flag = 1'b0;
   logic       receive_flag = 1'b0;
   logic [7:0] rx_data = 8'h00;
   tx_state_e  dbg_state;

   always #5 clock = ~clock;

   uart_mmio_ctrl #(.TX_DEPTH(TX_DEPTH)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .addr         (addr),
      .w_data       (w_data),
      .mem_w_en     (mem_w_en),
      .dmem_r_data  (dmem_r_data),
      .dmem_w_en    (dmem_w_en),
      .cpu_r_data   (cpu_r_data),
      .tx_en        (tx_en),
      .rx_en        (rx_en),
      .begin_flag   (begin_flag),
      .tx_data      (tx_data),
      .busy_flag    (busy_flag),
      .receive_flag (receive_flag),
      .rx_data      (rx_data),
      .dbg_state    (dbg_state)
   );

   // data_mem stand-in: combinational read, written only by the DUT's strobe
   logic [7:0] mem [256];
   assign dmem_r_data = mem[addr];
   always @(posedge clock) if (dmem_w_en) mem[addr] <= w_data;

   // ---------------- scoreboard state ----------------
   int         n_chk = 0;
   int         n_fail = 0;
   chk_t       chk_q[$];
   logic [7:0] exp_tx_q[$];
   logic       op_valid = 1'b0;

   // reference model of the register file
   logic       m_drop = 1'b0;
   logic       m_ovr = 1'b0;
   logic       m_valid = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] exp_mem [256];
   bit         written [256];
   int         wr_list[$];

   // UART core model controls
   int busy_mode = 0;   // 0: react to begin, 1: hold busy high, 2: never busy
   int blen_lo = 2;
   int blen_hi = 6;

   function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] m_status();
      logic [7:0] s;
      s = {2'b00, m_drop, busy_flag, m_ovr, m_valid,
           (exp_tx_q.size() == 0), (exp_tx_q.size() == TX_DEPTH)};
      return s;
   endfunction

   function automatic logic [7:0] exp_read(logic [7:0] a);
      if (a == A_TXDATA) return 8'h00;
      if (a == A_RXDATA) return m_hold;
      if (a == A_STATUS) return m_status();
      return exp_mem[a];
   endfunction

   function automatic bit is_uart(logic [7:0] a);
      return (a == A_TXDATA) || (a == A_RXDATA) || (a == A_STATUS);
   endfunction

   // a receive edge, optionally in the same cycle as a STATUS write of clr
   function automatic void model_rx(logic [7:0] b, logic [7:0] clr);
      logic ovr_new;
      ovr_new = (m_ovr && !clr[3]) || (m_valid && !clr[2]);
      if (clr[5]) m_drop = 1'b0;
      m_ovr   = ovr_new;
      m_valid = 1'b1;
      m_hold  = b;
   endfunction

   function automatic void model_store(logic [7:0] a, logic [7:0] d);
      if (a == A_TXDATA) begin
         if (exp_tx_q.size() < TX_DEPTH) exp_tx_q.push_back(d);
         else m_drop = 1'b1;
      end else if (a == A_STATUS) begin
         if (d[5]) m_drop = 1'b0;
         if (d[3]) m_ovr = 1'b0;
         if (d[2]) m_valid = 1'b0;
      end else if (a != A_RXDATA) begin
         exp_mem[a] = d;
         if (!written[a]) begin
            written[a] = 1'b1;
            wr_list.push_back(int'(a));
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
      mem_w_en = 1'b0;
      op_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic expect_sig(int kind, logic [7:0] val);
      op_valid = 1'b1;
      chk_q.push_back('{kind, val});
   endtask

   task automatic store(logic [7:0] a, logic [7:0] d);
      step();
      addr = a;
      w_data = d;
      mem_w_en = 1'b1;
      model_store(a, d);
      expect_sig(K_DWEN, {7'b0, !is_uart(a)});
   endtask

   task automatic read(logic [7:0] a);
      step();
      addr = a;
      expect_sig(K_RD, exp_read(a));
   endtask

   task automatic rx_pulse(logic [7:0] b);
      step();
      rx_data = b;
      receive_flag = 1'b1;
      model_rx(b, 8'h00);
      idle($urandom_range(1, 3));
      step();
      receive_flag = 1'b0;
   endtask

   // receive edge in the same cycle as a STATUS write
   task automatic rx_with_clear(logic [7:0] b, logic [7:0] clr);
      step();
      addr = A_STATUS;
      w_data = clr;
      mem_w_en = 1'b1;
      rx_data = b;
      receive_flag = 1'b1;
      model_rx(b, clr);
      expect_sig(K_DWEN, 8'h00);
      idle(2);
      step();
      receive_flag = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_tx_q.size() > 0 && t < 300) begin
         step();
         t++;
      end
      if (exp_tx_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_tx_q.size());
         exp_tx_q.delete();
      end
   endtask

   function automatic void model_reset();
      exp_tx_q.delete();
      m_drop  = 1'b0;
      m_ovr   = 1'b0;
      m_valid = 1'b0;
      m_hold  = 8'h00;
   endfunction

   // ---------------- UART core model ----------------
   int dly = 0;
   int blen = 0;
   always @(negedge clock) begin
      #1;
      if (busy_mode == 1) begin
         busy_flag = 1'b1;
      end else if (busy_mode == 2) begin
         busy_flag = 1'b0;
         dly = 0;
         blen = 0;
      end else if (reset_n && begin_flag) begin
         dly = $urandom_range(1, 2);
         blen = $urandom_range(blen_lo, blen_hi);
         busy_flag = 1'b0;
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) busy_flag = 1'b1;
      end else if (blen > 0) begin
         blen--;
         if (blen == 0) busy_flag = 1'b0;
      end else begin
         busy_flag = 1'b0;
      end
   end

   // ---------------- monitor ----------------
   int         cyc = 0;
   int         last_begin = 0;
   bit         gap_ok = 1'b0;
   bit         tx_pend = 1'b0;
   logic [7:0] tx_exp = 8'h00;
   always @(negedge clock) begin
      chk_t e;
      if (op_valid) begin
         while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            case (e.kind)
               K_DWEN:  check("dmem_w_en", {7'b0, dmem_w_en}, e.val);
               K_RD:    check("cpu_r_data", cpu_r_data, e.val);
               K_EN:    check("tx_rx_en", {6'b0, tx_en, rx_en}, e.val);
               K_BEGIN: check("begin_flag", {7'b0, begin_flag}, e.val);
               K_TXD:   check("tx_data_reg", tx_data, e.val);
               default: check("tx_state", {6'b0, dbg_state}, e.val);
            endcase
         end
      end
      if (!reset_n) begin
         tx_pend = 1'b0;
         gap_ok = 1'b0;
      end else begin
         if (tx_pend) begin
            check("tx_data", tx_data, tx_exp);
            check("begin_width", {7'b0, begin_flag}, 8'h00);
            tx_pend = 1'b0;
         end
         if (begin_flag) begin
            if (exp_tx_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_begin: got begin with tx_data %02h expected no begin", tx_data);
            end else begin
               tx_exp = exp_tx_q.pop_front();
               tx_pend = 1'b1;
            end
            if (gap_ok && busy_mode == 2) check("timeout_gap", 8'(cyc - last_begin), 8'd6);
            last_begin = cyc;
            gap_ok = (busy_mode == 2);
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] a;
      int         n;
      int         t;

      // reset values
      step();
      expect_sig(K_EN, 8'h00);
      expect_sig(K_BEGIN, 8'h00);
      expect_sig(K_TXD, 8'h00);
      expect_sig(K_STATE, 8'(TX_IDLE));
      addr = A_STATUS;
      expect_sig(K_RD, m_status());
      read(A_RXDATA);
      step();
      reset_n = 1'b1;
      step();
      expect_sig(K_EN, 8'h03);

      // single byte, long busy
      blen_lo = 10;
      blen_hi = 10;
      store(A_TXDATA, 8'h41);
      wait_drain();
      idle(3);
      read(A_STATUS);
      idle(15);
      read(A_STATUS);
      blen_lo = 2;
      blen_hi = 6;

      // overflow while the UART is busy
      busy_mode = 1;
      idle(2);
      for (int i = 0; i < 6; i++) store(A_TXDATA, 8'($urandom));
      read(A_STATUS);
      busy_mode = 0;
      wait_drain();
      idle(15);
      read(A_STATUS);
      store(A_STATUS, 8'h20);
      read(A_STATUS);

      // pass-through to data_mem
      store(8'h10, 8'h55);
      read(8'h10);
      store(A_RXDATA, 8'h99);
      read(A_RXDATA);
      read(A_TXDATA);

      // receive capture and overrun
      rx_pulse(8'h7E);
      read(A_RXDATA);
      read(A_STATUS);
      rx_pulse(8'h33);
      read(A_STATUS);
      read(A_RXDATA);
      store(A_STATUS, 8'h0C);
      read(A_STATUS);

      // receive edge racing a clear of rx_valid
      rx_pulse(8'hA5);
      rx_with_clear(8'h5A, 8'h04);
      read(A_STATUS);
      read(A_RXDATA);
      store(A_STATUS, 8'h0C);

      // busy never arrives: sequencer times out and moves on
      busy_mode = 2;
      store(A_TXDATA, 8'hC3);
      store(A_TXDATA, 8'h3C);
      wait_drain();
      idle(8);
      read(A_STATUS);
      busy_mode = 0;

      // reset while a byte is in flight
      blen_lo = 20;
      blen_hi = 20;
      store(A_TXDATA, 8'h11);
      store(A_TXDATA, 8'h22);
      store(A_TXDATA, 8'h33);
      t = 0;
      while (!busy_flag && t < 20) begin
         step();
         t++;
      end
      expect_sig(K_STATE, 8'(TX_WAIT_DONE));
      step();
      reset_n = 1'b0;
      #1;
      model_reset();
      busy_mode = 2;
      addr = A_STATUS;
      expect_sig(K_BEGIN, 8'h00);
      expect_sig(K_EN, 8'h00);
      expect_sig(K_STATE, 8'(TX_IDLE));
      expect_sig(K_RD, m_status());
      step();
      addr = A_STATUS;
      expect_sig(K_RD, m_status());
      step();
      reset_n = 1'b1;
      step();
      expect_sig(K_EN, 8'h03);
      busy_mode = 0;
      blen_lo = 2;
      blen_hi = 6;
      idle(2);

      // random traffic
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 5))
            0: store(8'($urandom_range(0, 252)), 8'($urandom));
            1: if (wr_list.size() > 0) read(8'(wr_list[$urandom_range(0, wr_list.size() - 1)]));
            2: if (exp_tx_q.size() == 0) begin
                  n = $urandom_range(1, 4);
                  repeat (n) store(A_TXDATA, 8'($urandom));
               end
            3: rx_pulse(8'($urandom));
            4: begin
                  a = 8'($urandom_range(253, 255));
                  read(a);
               end
            default: store(A_STATUS, 8'($urandom));
         endcase
      end

      wait_drain();
      idle(20);
      read(A_STATUS);
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
